tx_scramble_ctrl: RTL and testbench

- Sequences the TX bit scrambler to build the 802.11a DATA field for one frame: SERVICE (16 bits), PSDU, TAIL (6 bits), PAD to a whole number of OFDM symbols.
- Sits between the PSDU bit serializer (upstream) and the convolutional encoder (downstream).
- Drives the scrambler's init/enable/data pins and forces TAIL bits to zero after scrambling.

---
 rtl/tx_pkg.sv | 32 +++
 rtl/tx_scramble_ctrl_if.sv | 11 +
 rtl/tx_scrambler.sv | 29 ++
 rtl/tx_scramble_ctrl.sv | 128 ++++++++++++
 tb/tb_tx_scramble_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the 802.11a TX DATA-field scrambler sequencer.
// The scrambler is x^7 + x^4 + 1. The sequencer reloads it with SCR_SEED at the start of every frame.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SERVICE,
    PSDU,
    TAIL,
    PAD,
    DONE
  } phase_t;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  localparam logic [6:0] SCR_SEED = 7'b1011101;

  localparam int NDBPS_NUM = 8;
  localparam int NDBPS_LEGAL [NDBPS_NUM] = '{24, 36, 48, 72, 96, 144, 192, 216};

  function automatic bit ndbps_is_legal(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NDBPS_NUM; i++) begin
      if (NDBPS_LEGAL[i] == n) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/tx_scramble_ctrl_if.sv
// Single-bit valid/ready stream with an end-of-field marker.
// The master drives vld/dat/last. The slave drives rdy.
interface tx_scramble_ctrl_if;
  logic vld;
  logic dat;
  logic last;
  logic rdy;

  modport master (output vld, dat, last, input rdy);
  modport slave  (input vld, dat, last, output rdy);
endinterface

// File: rtl/tx_scrambler.sv
// 802.11a frame-synchronous scrambler (x^7 + x^4 + 1). Output is combinational from din.
// The state advances only on en. init reloads the seed.
module tx_scrambler
  import tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic init,
  input  logic en,
  input  logic din,
  output logic dout
);

  // lfsr[6] is the oldest tap (x^7). lfsr[3] is the x^4 tap.
  logic [6:0] lfsr;
  logic       fb;

  assign fb   = lfsr[6] ^ lfsr[3];
  assign dout = din ^ fb;

  always_ff @(posedge clk) begin
    if (reset || init) begin
      lfsr <= SCR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[5:0], fb};
    end
  end

endmodule

// File: rtl/tx_scramble_ctrl.sv
// Sequences SERVICE/PSDU/TAIL/PAD through the scrambler to form one 802.11a DATA field.
// Outputs are decoded combinationally from state. In PSDU, src and enc handshake in pass-through.
module tx_scramble_ctrl
  import tx_pkg::*;
#(
  parameter int N_DBPS = 24,
  parameter int LEN_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] psdu_len,
  output logic             busy,
  output logic             done,
  tx_scramble_ctrl_if.slave  src,
  tx_scramble_ctrl_if.master enc,
  output logic             scr_init,
  output logic             scr_en,
  output logic             scr_din,
  input  logic             scr_dout
);

  localparam int CNT_W = LEN_W + 3;
  localparam int SYM_W = (N_DBPS > 1) ? $clog2(N_DBPS) : 1;

  localparam logic [CNT_W-1:0] SVC_LAST  = CNT_W'(SERVICE_BITS - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BITS - 1);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(N_DBPS - 1);

  phase_t           state;
  phase_t           state_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] len_bits;
  logic [SYM_W-1:0] sym_cnt;
  logic             xfer;
  logic             sym_wrap;
  logic             phase_end;

  assign xfer     = enc.vld & enc.rdy;
  assign sym_wrap = (sym_cnt == SYM_LAST);
  assign scr_en   = xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    scr_init  = 1'b0;
    scr_din   = 1'b0;
    src.rdy   = 1'b0;
    enc.vld   = 1'b0;
    enc.dat   = 1'b0;
    enc.last  = 1'b0;
    phase_end = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        busy      = 1'b1;
        scr_init  = 1'b1;
        state_nxt = SERVICE;
      end
      SERVICE: begin
        busy      = 1'b1;
        enc.vld   = 1'b1;
        enc.dat   = scr_dout;
        phase_end = (phase_cnt == SVC_LAST);
        if (xfer && phase_end) state_nxt = (len_bits == '0) ? TAIL : PSDU;
      end
      PSDU: begin
        busy      = 1'b1;
        enc.vld   = src.vld;
        src.rdy   = enc.rdy;
        scr_din   = src.dat;
        enc.dat   = scr_dout;
        phase_end = (phase_cnt == len_bits - CNT_W'(1));
        if (xfer && phase_end) state_nxt = TAIL;
      end
      TAIL: begin
        // Tail bits still clock the scrambler, but the encoder must see zeros.
        busy      = 1'b1;
        enc.vld   = 1'b1;
        phase_end = (phase_cnt == TAIL_LAST);
        enc.last  = phase_end && sym_wrap;
        if (xfer && phase_end) state_nxt = sym_wrap ? DONE : PAD;
      end
      PAD: begin
        busy     = 1'b1;
        enc.vld  = 1'b1;
        enc.dat  = scr_dout;
        enc.last = sym_wrap;
        if (xfer && sym_wrap) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_cnt <= '0;
      sym_cnt   <= '0;
      len_bits  <= '0;
    end else begin
      if (state == IDLE && start) len_bits <= {psdu_len, 3'b000};
      if (state == INIT) begin
        phase_cnt <= '0;
        sym_cnt   <= '0;
      end else if (xfer) begin
        phase_cnt <= phase_end ? '0 : phase_cnt + CNT_W'(1);
        sym_cnt   <= sym_wrap ? '0 : sym_cnt + SYM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_scramble_ctrl.sv
// Directed bench: three sequencer+scrambler pairs (N_DBPS 24/38/48) sharing stimulus, selected by sel.
`timescale 1ns/1ps
module tb_tx_scramble_ctrl;
  import tx_pkg::*;

  localparam int LEN_W = 12;
  localparam int NI    = 3;
  localparam int MAXB  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             start;
  logic [LEN_W-1:0] psdu_len;
  logic             in_valid;
  logic             in_bit;
  logic             out_ready;
  int               sel;
  bit               stall;
  int               clr_tok;

  logic [NI-1:0] bz, dn, ov, ob, ol, ir, si, se;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int NDB_G = (g == 0) ? 24 : (g == 1) ? 38 : 48;
    tx_scramble_ctrl_if src_if ();
    tx_scramble_ctrl_if enc_if ();
    logic busy, done, scr_init, scr_en, scr_din, scr_dout, start_g;

    assign start_g       = start && (sel == g);
    assign src_if.vld    = in_valid;
    assign src_if.dat    = in_bit;
    assign src_if.last   = 1'b0;
    assign enc_if.rdy    = out_ready;

    tx_scramble_ctrl #(.N_DBPS(NDB_G), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .start(start_g), .psdu_len(psdu_len),
      .busy(busy), .done(done), .src(src_if), .enc(enc_if),
      .scr_init(scr_init), .scr_en(scr_en), .scr_din(scr_din), .scr_dout(scr_dout)
    );

    tx_scrambler scr (
      .clk(clk), .reset(reset), .init(scr_init), .en(scr_en), .din(scr_din), .dout(scr_dout)
    );

    assign bz[g] = busy;
    assign dn[g] = done;
    assign ov[g] = enc_if.vld;
    assign ob[g] = enc_if.dat;
    assign ol[g] = enc_if.last;
    assign ir[g] = src_if.rdy;
    assign si[g] = scr_init;
    assign se[g] = scr_en;
  end

  // Reference sequence and stimulus data (written by the initial block only).
  logic exp_seq   [0:MAXB-1];
  logic psdu_bits [0:MAXB-1];

  // Capture state (written by the monitor only).
  logic cap_bit  [0:MAXB-1];
  logic save_bit [0:MAXB-1];
  int   cap_n, last_n, last_idx, last_cyc, done_n, done_cyc, en_n, in_idx, cyc, seen_tok;
  logic done_busy;

  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    cyc++;
    if (clr_tok != seen_tok) begin
      seen_tok = clr_tok;
      cap_n    = 0;
      last_n   = 0;
      last_idx = -1;
      last_cyc = 0;
      done_n   = 0;
      done_cyc = 0;
      en_n     = 0;
      in_idx   = 0;
    end
    if (ov[sel] && out_ready) begin
      if (cap_n < MAXB) cap_bit[cap_n] = ob[sel];
      if (ol[sel]) begin
        last_n++;
        last_idx = cap_n;
        last_cyc = cyc;
      end
      cap_n++;
    end
    if (ir[sel] && in_valid) in_idx++;
    if (se[sel]) en_n++;
    if (dn[sel]) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = bz[sel];
    end
    out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    in_bit    = (in_idx < MAXB) ? psdu_bits[in_idx] : 1'b0;
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input int k, input int lb);
    if (k >= 16 + lb && k < 22 + lb) return 1'b0;
    if (k >= 16 && k < 16 + lb) return exp_seq[k] ^ psdu_bits[k - 16];
    return exp_seq[k];
  endfunction

  task automatic run_frame(input int s, input int len, input bit stl, input bit poke_start);
    int t;
    sel      = s;
    psdu_len = LEN_W'(len);
    stall    = stl;
    clr_tok++;
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    t = 0;
    while (done_n == 0 && t < 2000) begin
      @(posedge clk); #2;
      t++;
      start = (poke_start && t == 10) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic check_frame(input string tg, input int exp_total, input int lb);
    int mism;
    mism = 0;
    for (int k = 0; k < exp_total && k < MAXB; k++) begin
      if (cap_bit[k] !== exp_bit(k, lb)) mism++;
    end
    chk_eq({tg, "_nbits"},    cap_n, exp_total);
    chk_eq({tg, "_nlast"},    last_n, 1);
    chk_eq({tg, "_last_idx"}, last_idx, exp_total - 1);
    chk_eq({tg, "_done_lag"}, done_cyc - last_cyc, 1);
    chk_eq({tg, "_scr_en"},   en_n, exp_total);
    chk_eq({tg, "_bits"},     mism, 0);
    chk_eq({tg, "_done_n"},   done_n, 1);
  endtask

  function automatic int first7();
    int v;
    v = 0;
    for (int i = 0; i < 7; i++) v = (v << 1) | int'(cap_bit[i]);
    return v;
  endfunction

  initial begin
    logic h [0:MAXB+6];
    logic [7:0] bytes5 [0:4];
    int orv, diff, t;

    // Scrambler output obeys s[k] = s[k-4] ^ s[k-7]; h[0..6] hold s[-7..-1] from seed 1011101.
    h[0] = 1; h[1] = 0; h[2] = 1; h[3] = 1; h[4] = 1; h[5] = 0; h[6] = 1;
    for (int i = 7; i < MAXB + 7; i++) h[i] = h[i-4] ^ h[i-7];
    for (int i = 0; i < MAXB; i++) begin
      exp_seq[i]   = h[i + 7];
      psdu_bits[i] = 1'b0;
    end

    reset = 1'b1; start = 1'b0; psdu_len = '0; sel = 0; stall = 1'b0; clr_tok = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_eq("rst_outs", int'({bz, dn, ov, ol, ir, si, se}), 0);
    reset = 1'b0;
    @(posedge clk); #2;
    chk_eq("idle_outs", int'({bz, dn, ov, ol, ir, si, se}), 0);

    // psdu_len=0, N_DBPS=24: 16 service, 6 tail, 2 pad.
    run_frame(0, 0, 1'b0, 1'b0);
    check_frame("len0", 24, 0);
    chk_eq("len0_first7", first7(), 7'b0110110);
    orv = 0;
    for (int i = 16; i < 22; i++) orv |= int'(cap_bit[i]);
    chk_eq("len0_tail_zero", orv, 0);
    chk_eq("len0_busy_at_done", int'(done_busy), 0);

    // psdu_len=1 of zeros: output is the free-running scrambler sequence apart from the tail.
    run_frame(0, 1, 1'b0, 1'b0);
    check_frame("len1", 48, 8);

    // N_DBPS=38, psdu_len=2: 16+16+6 fills the symbol exactly, so there is no pad.
    for (int i = 0; i < 16; i++) psdu_bits[i] = 1'(i % 3 == 0);
    run_frame(1, 2, 1'b0, 1'b0);
    check_frame("nopad", 38, 16);

    // N_DBPS=48, psdu_len=5. Run without stalls, then with random stalls and source gaps.
    bytes5[0] = 8'hA5; bytes5[1] = 8'h3C; bytes5[2] = 8'h01; bytes5[3] = 8'hFF; bytes5[4] = 8'h96;
    for (int i = 0; i < 40; i++) psdu_bits[i] = bytes5[i / 8][i % 8];
    run_frame(2, 5, 1'b0, 1'b0);
    check_frame("len5", 96, 40);
    for (int i = 0; i < 96; i++) save_bit[i] = cap_bit[i];
    run_frame(2, 5, 1'b1, 1'b0);
    check_frame("len5_stall", 96, 40);
    diff = 0;
    for (int i = 0; i < 96; i++) if (cap_bit[i] !== save_bit[i]) diff++;
    chk_eq("len5_stall_vs_nostall", diff, 0);
    stall = 1'b0;

    // A start pulse in mid-frame must be ignored.
    run_frame(0, 0, 1'b0, 1'b1);
    check_frame("start_busy", 24, 0);

    // Reset while SERVICE bit 9 is on the output: immediate abort, no done pulse.
    sel = 0; psdu_len = '0; clr_tok++;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    t = 0;
    while (cap_n < 8 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    chk_eq("abort_reached_bit9", cap_n, 8);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_eq("abort_rst_outs", int'({bz, dn, ov, ol, ir, si, se}), 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk_eq("abort_no_done", done_n, 0);
    chk_eq("abort_idle_outs", int'({bz, dn, ov, ol, ir, si, se}), 0);

    run_frame(0, 0, 1'b0, 1'b0);
    chk_eq("after_abort_first7", first7(), 7'b0110110);
    check_frame("after_abort", 24, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
